// File: rtl/spu_local_store_pkg.sv
// defines_pkg: shared local-store geometry, index types and fill FSM states.
package defines_pkg;
   localparam int LS_BYTES  = 32768;
   localparam int LINE_QW   = 4;
   localparam int DATA_WD   = 128;
   localparam int ADDR_WD   = 32;
   localparam int QW_SHIFT  = 4;
   localparam int QW_IDX_WD = $clog2(LS_BYTES / 16);
   localparam int BEAT_WD   = $clog2(LINE_QW);
   localparam int LINE_WD   = QW_IDX_WD - BEAT_WD;
   typedef logic [QW_IDX_WD-1:0] ls_idx_t;
   typedef logic [LINE_WD-1:0] line_t;
   typedef logic [BEAT_WD-1:0] beat_t;
   typedef enum logic {FILL_IDLE, FILL_ACTIVE} fill_state_t;
   // Truncation drops the upper bits, so addresses alias modulo LS_BYTES.
   function automatic ls_idx_t qw_idx(input logic [0:ADDR_WD-1] a);
      return ls_idx_t'(a >> QW_SHIFT);
   endfunction
endpackage

// File: rtl/ls_sram_2p.sv
// ls_sram_2p: quadword array; port A write-first read/write, port B read-only
// with a bypass from a same-cycle port A write. Storage is never reset.
module ls_sram_2p
   import defines_pkg::*;
(
   input  logic               clk,
   input  ls_idx_t            i_a_idx,
   input  logic               i_a_we,
   input  logic [0:DATA_WD-1] i_a_wdata,
   output logic [0:DATA_WD-1] o_a_rdata,
   input  ls_idx_t            i_b_idx,
   output logic [0:DATA_WD-1] o_b_rdata
);
   logic [0:DATA_WD-1] r_mem [0:LS_BYTES/16-1];
   always_ff @(posedge clk) begin
      if (i_a_we) r_mem[i_a_idx] <= i_a_wdata;
      o_a_rdata <= i_a_we ? i_a_wdata : r_mem[i_a_idx];
      o_b_rdata <= (i_a_we && i_a_idx == i_b_idx) ? i_a_wdata : r_mem[i_b_idx];
   end
endmodule

// File: rtl/spu_local_store.sv
// spu_local_store: SPU local store with a load/store data port and an
// instruction-line fill port sequenced by a fill FSM with one pending request.
module spu_local_store
   import defines_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic [0:ADDR_WD-1] ls_addr,
   input  logic               ls_wr_en,
   input  logic [0:DATA_WD-1] ls_data_wr,
   output logic [0:DATA_WD-1] ls_data_rd,
   input  logic               cache_wr,
   input  logic [0:ADDR_WD-1] fill_addr,
   output logic               fill_valid,
   output logic [0:DATA_WD-1] fill_data,
   output logic [0:BEAT_WD-1] fill_beat,
   output logic               fill_last,
   output logic               fill_busy
);
   fill_state_t r_state, w_next;
   line_t r_line, r_pend_line, w_req_line;
   beat_t r_beat, r_out_beat;
   ls_idx_t w_ls_idx, w_req_idx;
   logic r_pend, r_rst_q, r_valid, r_last;
   logic w_issue, w_last_issue, w_start;
   logic [0:DATA_WD-1] w_a_rd, w_b_rd;

   assign w_ls_idx   = qw_idx(ls_addr);
   assign w_req_idx  = qw_idx(fill_addr);
   assign w_req_line = line_t'(w_req_idx >> BEAT_WD);

   ls_sram_2p u_sram (
      .clk       (clk),
      .i_a_idx   (w_ls_idx),
      .i_a_we    (ls_wr_en),
      .i_a_wdata (ls_data_wr),
      .o_a_rdata (w_a_rd),
      .i_b_idx   ({r_line, r_beat}),
      .o_b_rdata (w_b_rd)
   );

   // A request taken on the last beat with nothing pending starts the next line directly.
   always_comb begin
      w_issue      = r_state == FILL_ACTIVE;
      w_last_issue = w_issue && r_beat == beat_t'(LINE_QW - 1);
      w_start      = cache_wr && (!w_issue || (w_last_issue && !r_pend));
   end

   always_comb begin
      w_next = (w_start || (w_issue && !w_last_issue) || (w_last_issue && r_pend))
             ? FILL_ACTIVE : FILL_IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= FILL_IDLE;
         r_pend     <= 1'b0;
         r_beat     <= '0;
         r_valid    <= 1'b0;
         r_last     <= 1'b0;
         r_out_beat <= '0;
         r_rst_q    <= 1'b1;
      end else begin
         r_state    <= w_next;
         r_rst_q    <= 1'b0;
         r_valid    <= w_issue;
         r_last     <= w_last_issue;
         r_out_beat <= r_beat;
         r_beat     <= w_start ? '0 : r_beat + beat_t'(w_issue);
         if (w_start) r_line <= w_req_line;
         else if (w_last_issue && r_pend) r_line <= r_pend_line;
         if (cache_wr && !w_start) begin
            r_pend      <= 1'b1;
            r_pend_line <= w_req_line;
         end else if (w_last_issue) r_pend <= 1'b0;
      end
   end

   // The array is not reset, so its registered outputs are masked here.
   assign ls_data_rd = r_rst_q ? '0 : w_a_rd;
   assign fill_data  = r_valid ? w_b_rd : '0;
   assign fill_valid = r_valid;
   assign fill_beat  = r_out_beat;
   assign fill_last  = r_last;
   assign fill_busy  = w_issue | r_pend | r_valid;
endmodule
